arm_cache_controller: RTL

- Sits between the MEM stage and the SRAM controller and drives the 2-way data cache.
- Reads: a hit is served from the cache in the same cycle. A miss fetches a 64-bit line (two words) from SRAM, fills the cache and returns the requested word.
- Writes: write-through and no-write-allocate. The matching cache line is invalidated, then the word is written to SRAM.
- `ready` low stalls the pipeline. The MEM stage holds its request stable while `ready` is low.

---
 rtl/arm_mem_pkg.sv | 19 +
 rtl/arm_cache_controller.sv | 103 ++++++++++
 2 files changed

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the data-memory path: FSM states, memory base and cache address fields.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_READ_MISS = 2'd1,
        S_FILL      = 2'd2,
        S_WRITE     = 2'd3
    } state_e;

    localparam int unsigned BASE_ADDR = 1024;

    localparam int unsigned TAG_MSB  = 18;
    localparam int unsigned TAG_LSB  = 9;
    localparam int unsigned IDX_MSB  = 8;
    localparam int unsigned IDX_LSB  = 3;
    localparam int unsigned WORD_SEL = 2;

endpackage

// File: rtl/arm_cache_controller.sv
// Data cache controller between the MEM stage and the SRAM controller: read-allocate on miss,
// write-through with no write-allocate.
module arm_cache_controller
    import arm_mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR    = arm_mem_pkg::BASE_ADDR,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned CACHE_ADDR_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MEM_R_EN,
    input  logic                    MEM_W_EN,
    input  logic [ADDR_W-1:0]       address,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    output logic                    ready,
    output logic [CACHE_ADDR_W-1:0] cache_address,
    input  logic                    cache_hit,
    input  logic [31:0]             cache_rdata,
    output logic                    cache_write_en,
    output logic [31:0]             cache_wdata1,
    output logic [31:0]             cache_wdata2,
    output logic                    cache_invalidate,
    output logic [CACHE_ADDR_W-1:0] sram_address,
    output logic [31:0]             sram_wdata,
    output logic                    sram_read_en,
    output logic                    sram_write_en,
    input  logic [63:0]             sram_rdata,
    input  logic                    sram_ready
);

    state_e      state_q, state_d;
    logic [63:0] line_q, line_d;

    assign cache_address = CACHE_ADDR_W'(address - ADDR_W'(BASE_ADDR));
    assign sram_address  = cache_address;
    assign sram_wdata    = wdata;
    assign cache_wdata1  = line_q[31:0];
    assign cache_wdata2  = line_q[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        line_d           = line_q;
        ready            = 1'b0;
        rdata            = '0;
        cache_write_en   = 1'b0;
        cache_invalidate = 1'b0;
        sram_read_en     = 1'b0;
        sram_write_en    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A store wins over a simultaneous load; the load is dropped.
                if (MEM_W_EN) begin
                    cache_invalidate = 1'b1;
                    state_d          = S_WRITE;
                end else if (MEM_R_EN) begin
                    if (cache_hit) begin
                        ready = 1'b1;
                        rdata = cache_rdata;
                    end else begin
                        state_d = S_READ_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            S_READ_MISS: begin
                sram_read_en = 1'b1;
                if (sram_ready) begin
                    line_d  = sram_rdata;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                cache_write_en = 1'b1;
                ready          = 1'b1;
                rdata          = address[WORD_SEL] ? line_q[63:32] : line_q[31:0];
                state_d        = S_IDLE;
            end
            S_WRITE: begin
                sram_write_en = 1'b1;
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
